pll_reset_sequencer: RTL and testbench
======================================

Name: pll_reset_sequencer

Overview:
- Sits directly downstream of the ECPIX-5 PLL wrapper and runs in the PLL's 40 MHz output domain.
- Consumes the PLL `locked` flag, qualifies it for stability, then holds the design reset for a programmable stretch before releasing it synchronously.
- Produces the active-high reset that clocks all generated design logic, plus an active-low copy and status.
- Re-asserts reset immediately on loss of lock and counts lock-loss events.

Parameters:
- LOCK_CYCLES, 1024: consecutive synchronized-locked cycles required before leaving qualification. Must be >= 1.
- HOLD_CYCLES, 16: cycles reset stays asserted after qualification. Must be >= 1.
- CNT_W, 16: width of the shared qualify/hold counter. Must hold max(LOCK_CYCLES, HOLD_CYCLES) - 1.

Ports:
- clock, input, 1: 40 MHz PLL output clock.
- reset_n, input, 1: asynchronous active-low reset (board button / power-on).
- pll_locked, input, 1: PLL lock flag, treated as asynchronous.
- rst_out, output, 1: active-high design reset, registered.
- rst_out_n, output, 1: inverse of rst_out, registered.
- running, output, 1: high when state is RUN.
- lock_loss_count, output, 8: saturating count of RUN->WAIT_LOCK transitions.

Behaviour:
- Reset: clock is the single clock; reset_n is asynchronous active-low.
  - reset_n low immediately (asynchronously) forces: sync flops = 0, state = WAIT_LOCK, cnt = 0, rst_out = 1, rst_out_n = 0, running = 0, lock_loss_count = 0.
  - Deassertion is sampled on the clock; the FSM starts in WAIT_LOCK.
- Synchronizer: two-flop chain on pll_locked produces locked_s, which lags pll_locked by 2 edges. No other logic samples pll_locked directly.
- FSM states: WAIT_LOCK, QUALIFY, HOLD, RUN.
  - WAIT_LOCK: cnt = 0. If locked_s, go to QUALIFY.
  - QUALIFY:
    - If !locked_s, go to WAIT_LOCK with cnt = 0 (glitch restarts qualification).
    - Else if cnt == LOCK_CYCLES-1, go to HOLD with cnt = 0.
    - Else cnt++.
    - QUALIFY therefore occupies exactly LOCK_CYCLES cycles on a clean lock.
  - HOLD:
    - If !locked_s, go to WAIT_LOCK with cnt = 0.
    - Else if cnt == HOLD_CYCLES-1, go to RUN with cnt = 0.
    - Else cnt++.
  - RUN: if !locked_s, go to WAIT_LOCK and increment lock_loss_count, saturating at 255.
- Outputs:
  - rst_out <= (next_state != RUN), so rst_out changes on the same edge the state changes.
  - rst_out_n <= ~(next_state != RUN).
  - running <= (next_state == RUN).
  - rst_out and rst_out_n are always exact complements; there are no glitches (all outputs come from flops).
- Latency:
  - pll_locked rise sampled at edge 0: locked_s high after edge 1; QUALIFY after edge 2; HOLD after edge 2+LOCK_CYCLES; rst_out falls after edge 2+LOCK_CYCLES+HOLD_CYCLES.
  - pll_locked fall sampled at edge k: rst_out rises after edge k+2.
- Boundaries:
  - LOCK_CYCLES = 1 or HOLD_CYCLES = 1 gives a single-cycle stay in that state.
  - Lock loss in QUALIFY or HOLD does not increment lock_loss_count.
  - reset_n assertion mid-sequence aborts to the reset values immediately; lock_loss_count clears.
  - pll_locked toggling every cycle never reaches HOLD.

Test Plan (bench parameters LOCK_CYCLES=8, HOLD_CYCLES=4 unless stated):
- Power-on release:
  - Stimulus: reset_n low for 5 cycles, then high; pll_locked rises and is sampled at edge 0.
  - Required: rst_out = 1 through edge 13; rst_out = 0 and running = 1 after edge 14; rst_out_n always equals ~rst_out.
- Qualify glitch:
  - Stimulus: pll_locked high, then low for one cycle (sampled at edge 5), then high again.
  - Required: FSM returns to WAIT_LOCK; full 8+4 sequence restarts; rst_out falls 14 edges after the re-rise is sampled.
- Lock loss in RUN:
  - Stimulus: from RUN, pll_locked falls (sampled at edge k).
  - Required: rst_out = 1 and running = 0 after edge k+2; lock_loss_count 0->1.
  - On relock: full qualify + hold sequence again.
- Saturation:
  - Stimulus: 300 lock/unlock cycles, each reaching RUN.
  - Required: lock_loss_count stops at 255.
- Async reset mid-HOLD:
  - Stimulus: reset_n pulled low between clock edges during HOLD.
  - Required: rst_out = 1, running = 0, lock_loss_count = 0 immediately, without waiting for a clock edge.
- Minimum parameters:
  - Stimulus: LOCK_CYCLES=1, HOLD_CYCLES=1; lock sampled at edge 0.
  - Required: rst_out falls after edge 4.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies PLL lock, stretches and synchronously releases the design reset.
module pll_reset_sequencer #(
  parameter int LOCK_CYCLES = 1024,
  parameter int HOLD_CYCLES = 16,
  parameter int CNT_W       = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  output logic       rst_out,
  output logic       rst_out_n,
  output logic       running,
  output logic [7:0] lock_loss_count
);
  typedef enum logic [1:0] {WAIT_LOCK, QUALIFY, HOLD, RUN} state_t;
  state_t state, next_state;
  logic [CNT_W-1:0] cnt, next_cnt;
  logic sync1, locked_s, loss;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1           <= 1'b0;
      locked_s        <= 1'b0;
      state           <= WAIT_LOCK;
      cnt             <= '0;
      rst_out         <= 1'b1;
      rst_out_n       <= 1'b0;
      running         <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      sync1     <= pll_locked;
      locked_s  <= sync1;
      state     <= next_state;
      cnt       <= next_cnt;
      rst_out   <= next_state != RUN;
      rst_out_n <= next_state == RUN;
      running   <= next_state == RUN;
      if (loss && lock_loss_count != 8'hff) lock_loss_count <= lock_loss_count + 8'd1;
    end
  end
  // Any drop of the synchronized lock restarts from WAIT_LOCK with a cleared counter.
  always_comb begin
    next_state = state;
    next_cnt   = '0;
    loss       = 1'b0;
    case (state)
      WAIT_LOCK: next_state = locked_s ? QUALIFY : WAIT_LOCK;
      QUALIFY: begin
        next_state = !locked_s ? WAIT_LOCK : (cnt == CNT_W'(LOCK_CYCLES - 1)) ? HOLD : QUALIFY;
        next_cnt   = (next_state == QUALIFY) ? cnt + CNT_W'(1) : '0;
      end
      HOLD: begin
        next_state = !locked_s ? WAIT_LOCK : (cnt == CNT_W'(HOLD_CYCLES - 1)) ? RUN : HOLD;
        next_cnt   = (next_state == HOLD) ? cnt + CNT_W'(1) : '0;
      end
      RUN: begin
        next_state = locked_s ? RUN : WAIT_LOCK;
        loss       = !locked_s;
      end
      default: next_state = WAIT_LOCK;
    endcase
  end
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: two instances (8/4 and 1/1) checked against a lock-streak model plus literal expectations.
module tb_pll_reset_sequencer;
  logic clock = 1'b0, reset_n = 1'b0, pll_locked = 1'b0;
  logic [1:0] rst_out, rst_out_n, running;
  logic [7:0] llc [2];
  int total = 0, bad = 0;
  always #5 clock = ~clock;
  pll_reset_sequencer #(.LOCK_CYCLES(8), .HOLD_CYCLES(4), .CNT_W(4)) dut0 (
    .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked), .rst_out(rst_out[0]),
    .rst_out_n(rst_out_n[0]), .running(running[0]), .lock_loss_count(llc[0]));
  pll_reset_sequencer #(.LOCK_CYCLES(1), .HOLD_CYCLES(1), .CNT_W(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .pll_locked(pll_locked), .rst_out(rst_out[1]),
    .rst_out_n(rst_out_n[1]), .running(running[1]), .lock_loss_count(llc[1]));
  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask
  // Model: the FSM sees pll_locked two edges late; it runs once it has seen lock on LOCK+HOLD+1 consecutive edges.
  int thr [2] = '{13, 3};
  int p1, p2, streak;
  int m_cnt [2];
  bit m_run [2];
  bit nr;
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p1 = 0; p2 = 0; streak = 0;
      for (int i = 0; i < 2; i++) begin m_run[i] = 0; m_cnt[i] = 0; end
    end else begin
      streak = p2 ? streak + 1 : 0;
      p2 = p1;
      p1 = int'(pll_locked);
      for (int i = 0; i < 2; i++) begin
        nr = streak >= thr[i];
        if (m_run[i] && !nr && m_cnt[i] < 255) m_cnt[i]++;
        m_run[i] = nr;
      end
    end
  end
  always @(posedge clock) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_rst_out%0d", i), rst_out[i], !m_run[i]);
      chk($sformatf("model_rst_out_n%0d", i), rst_out_n[i], m_run[i]);
      chk($sformatf("model_running%0d", i), running[i], m_run[i]);
      chk($sformatf("model_llc%0d", i), llc[i], m_cnt[i]);
    end
  end
  task automatic step(input logic lk);
    @(negedge clock);
    pll_locked = lk;
    @(posedge clock);
    #1;
  endtask
  task automatic pulse_reset();
    @(negedge clock);
    reset_n = 0; pll_locked = 0;
    @(negedge clock);
    reset_n = 1;
  endtask
  initial begin
    repeat (5) @(negedge clock);
    chk("reset_rst_out", rst_out[0], 1);
    chk("reset_rst_out_n", rst_out_n[0], 0);
    chk("reset_running", running[0], 0);
    chk("reset_llc", llc[0], 0);
    reset_n = 1;
    for (int e = 0; e <= 14; e++) begin
      step(1'b1);
      if (e <= 13) chk("por_hold", rst_out[0], 1);
      else begin chk("por_release", rst_out[0], 0); chk("por_running", running[0], 1); end
      if (e == 3) chk("min_hold", rst_out[1], 1);
      if (e == 4) chk("min_release", rst_out[1], 0);
    end
    pulse_reset();
    for (int e = 0; e <= 20; e++) begin
      step(e != 5);
      if (e == 19) chk("glitch_hold", rst_out[0], 1);
      if (e == 20) chk("glitch_release", rst_out[0], 0);
    end
    for (int e = 0; e <= 22; e++) begin
      step(e < 3 || e >= 8);
      if (e == 4) chk("loss_still_run", rst_out[0], 0);
      if (e == 5) begin
        chk("loss_rst_out", rst_out[0], 1);
        chk("loss_running", running[0], 0);
        chk("loss_llc", llc[0], 1);
      end
      if (e == 21) chk("relock_hold", rst_out[0], 1);
      if (e == 22) chk("relock_release", rst_out[0], 0);
    end
    repeat (300) begin
      repeat (3) step(1'b0);
      repeat (16) step(1'b1);
    end
    chk("sat_llc0", llc[0], 255);
    chk("sat_llc1", llc[1], 255);
    repeat (3) step(1'b0);
    for (int e = 0; e <= 11; e++) step(1'b1);
    chk("hold_rst_out", rst_out[0], 1);
    chk("hold_llc", llc[0], 255);
    #2 reset_n = 0;
    #1;
    chk("async_rst_out", rst_out[0], 1);
    chk("async_rst_out_n", rst_out_n[0], 0);
    chk("async_running", running[0], 0);
    chk("async_llc", llc[0], 0);
    chk("async_running1", running[1], 0);
    repeat (3) @(negedge clock);
    reset_n = 1;
    repeat (4) step(1'b1);
    chk("after_reset_rst_out", rst_out[0], 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
